// File: rtl/block_field_ctrl_if.sv
// Signal bundle between the block-field controller and its environment
// (start/timer/hit inputs, per-block and game-status outputs).
interface block_field_ctrl_if #(
  parameter int N_BLOCKS = 8
);
  logic                start;
  logic [N_BLOCKS-1:0] hit;
  logic                tick;
  logic [N_BLOCKS-1:0] alive;
  logic [N_BLOCKS-1:0] kill;
  logic                bounce;
  logic [9:0]          y_offset;
  logic [7:0]          score;
  logic                win;
  logic                lose;
  logic [2:0]          state;

  modport master (
    output start, hit, tick,
    input  alive, kill, bounce, y_offset, score, win, lose, state
  );

  modport slave (
    input  start, hit, tick,
    output alive, kill, bounce, y_offset, score, win, lose, state
  );
endinterface

// File: rtl/block_field_ctrl.sv
// Game controller for a row of breakable blocks: resolves ball hits into
// single kills, descends the field on timer ticks, and decides win/lose.
module block_field_ctrl #(
  parameter int N_BLOCKS = 8,
  parameter int STEP     = 16,
  parameter int Y_LIMIT  = 160,
  parameter int HOLD     = 4
) (
  input  logic              clock,
  input  logic              reset,
  block_field_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PLAY    = 3'd1;
  localparam logic [2:0] S_KILL    = 3'd2;
  localparam logic [2:0] S_COOL    = 3'd3;
  localparam logic [2:0] S_DESCEND = 3'd4;
  localparam logic [2:0] S_WIN     = 3'd5;
  localparam logic [2:0] S_LOSE    = 3'd6;

  localparam int          IDX_W     = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
  localparam int          CNT_W     = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
  localparam logic [10:0] STEP_EXT  = 11'(STEP);
  localparam logic [10:0] LIMIT_EXT = 11'(Y_LIMIT);

  logic [2:0]          state_reg,    state_next;
  logic [N_BLOCKS-1:0] alive_reg,    alive_next;
  logic [N_BLOCKS-1:0] kill_reg,     kill_next;
  logic                bounce_reg,   bounce_next;
  logic [9:0]          y_offset_reg, y_offset_next;
  logic [7:0]          score_reg,    score_next;
  logic                win_reg,      win_next;
  logic                lose_reg,     lose_next;
  logic                pend_reg,     pend_next;
  logic [CNT_W-1:0]    cnt_reg,      cnt_next;

  logic [N_BLOCKS-1:0] masked;
  logic [IDX_W-1:0]    lowest_idx;
  logic [10:0]         y_sum;
  logic [9:0]          y_desc;

  // Lowest-index live hit wins; scanning downward leaves the smallest index.
  always_comb begin
    masked     = bus.hit & alive_reg;
    lowest_idx = '0;
    for (int i = N_BLOCKS - 1; i >= 0; i--) begin
      if (masked[i]) begin
        lowest_idx = IDX_W'(i);
      end
    end
    y_sum  = {1'b0, y_offset_reg} + STEP_EXT;
    y_desc = (y_sum > LIMIT_EXT) ? LIMIT_EXT[9:0] : y_sum[9:0];
  end

  always_comb begin
    state_next    = state_reg;
    alive_next    = alive_reg;
    kill_next     = '0;
    bounce_next   = 1'b0;
    y_offset_next = y_offset_reg;
    score_next    = score_reg;
    win_next      = win_reg;
    lose_next     = lose_reg;
    pend_next     = pend_reg;
    cnt_next      = cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_PLAY;
        end
      end
      S_PLAY: begin
        if (|masked) begin
          // kill_reg holds the latched winner as a one-hot for the KILL cycle.
          kill_next[lowest_idx]  = 1'b1;
          bounce_next            = 1'b1;
          alive_next[lowest_idx] = 1'b0;
          score_next = (score_reg == 8'hFF) ? score_reg : score_reg + 8'd1;
          if (bus.tick) begin
            pend_next = 1'b1;
          end
          state_next = S_KILL;
        end else if (bus.tick || pend_reg) begin
          pend_next     = 1'b0;
          y_offset_next = y_desc;
          state_next    = S_DESCEND;
        end
      end
      S_KILL: begin
        if (bus.tick) begin
          pend_next = 1'b1;
        end
        cnt_next = '0;
        if (alive_reg == '0) begin
          win_next   = 1'b1;
          state_next = S_WIN;
        end else begin
          state_next = S_COOL;
        end
      end
      S_COOL: begin
        if (bus.tick) begin
          pend_next = 1'b1;
        end
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = S_PLAY;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_DESCEND: begin
        if (bus.tick) begin
          pend_next = 1'b1;
        end
        if ({1'b0, y_offset_reg} >= LIMIT_EXT) begin
          lose_next  = 1'b1;
          state_next = S_LOSE;
        end else begin
          state_next = S_PLAY;
        end
      end
      S_WIN, S_LOSE: begin
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      alive_reg    <= '1;
      kill_reg     <= '0;
      bounce_reg   <= 1'b0;
      y_offset_reg <= '0;
      score_reg    <= '0;
      win_reg      <= 1'b0;
      lose_reg     <= 1'b0;
      pend_reg     <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      alive_reg    <= alive_next;
      kill_reg     <= kill_next;
      bounce_reg   <= bounce_next;
      y_offset_reg <= y_offset_next;
      score_reg    <= score_next;
      win_reg      <= win_next;
      lose_reg     <= lose_next;
      pend_reg     <= pend_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign bus.alive    = alive_reg;
  assign bus.kill     = kill_reg;
  assign bus.bounce   = bounce_reg;
  assign bus.y_offset = y_offset_reg;
  assign bus.score    = score_reg;
  assign bus.win      = win_reg;
  assign bus.lose     = lose_reg;
  assign bus.state    = state_reg;
endmodule

// File: doc/block_field_ctrl.md
BLOCK_FIELD_CTRL -- requirements
Module: block_field_ctrl

Interface
REQ-001 SHALL have parameter N_BLOCKS, default 8: number of managed blocks.
REQ-002 SHALL have parameter STEP, default 16: pixels added to y_offset per descent.
REQ-003 SHALL have parameter Y_LIMIT, default 160: y_offset value that ends the game as lost.
REQ-004 SHALL have parameter HOLD, default 4: cooldown cycles after a kill.
REQ-005 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: level; starts play from IDLE.
REQ-008 SHALL have port hit, input, N_BLOCKS bits: per-block ball-contact flags from the block instances.
REQ-009 SHALL have port tick, input, 1 bit: one-cycle descent request from the timer.
REQ-010 SHALL have port alive, output, N_BLOCKS bits: per-block existence mask.
REQ-011 SHALL have port kill, output, N_BLOCKS bits: one-hot, one-cycle destroy pulse.
REQ-012 SHALL have port bounce, output, 1 bit: one-cycle pulse telling the ball to reflect.
REQ-013 SHALL have port y_offset, output, 10 bits: common vertical offset added to every block's y.
REQ-014 SHALL have port score, output, 8 bits: count of destroyed blocks.
REQ-015 SHALL have port win, output, 1 bit: level high in WIN.
REQ-016 SHALL have port lose, output, 1 bit: level high in LOSE.
REQ-017 SHALL have port state, output, 3 bits: FSM state code (IDLE=0, PLAY=1, KILL=2, COOL=3, DESCEND=4, WIN=5, LOSE=6).

Function
REQ-018 SHALL register every output; no combinational path from any input to any output.
REQ-019 IDLE SHALL move to PLAY on the first edge where start=1, and SHALL ignore hit and tick.
REQ-020 PLAY SHALL form masked = hit & alive; a nonzero masked SHALL latch the index of its lowest set bit as winner and move to KILL.
REQ-021 PLAY with masked=0 and (tick=1 or pend=1) SHALL clear pend and move to DESCEND.
REQ-022 A hit SHALL take priority over tick in the same cycle; that tick SHALL set pend.
REQ-023 A tick arriving in KILL, COOL or DESCEND SHALL set pend; pend SHALL hold one request only, further ticks merging into it.
REQ-024 KILL SHALL last exactly one cycle, driving kill[winner]=1 and bounce=1, clearing alive[winner] and incrementing score (saturating at 255).
REQ-025 After KILL: if alive becomes all-zero, SHALL enter WIN; otherwise SHALL enter COOL.
REQ-026 COOL SHALL last HOLD cycles, ignoring hit, then return to PLAY; an internal counter SHALL count 0..HOLD-1.
REQ-027 Hits on blocks with alive=0 SHALL never cause kill, bounce or a score change.
REQ-028 DESCEND SHALL last one cycle with y_offset <= min(y_offset+STEP, Y_LIMIT), computed in 11 bits to avoid wrap.
REQ-029 After DESCEND: if the new y_offset >= Y_LIMIT, SHALL enter LOSE; otherwise PLAY.
REQ-030 WIN and LOSE SHALL be terminal until reset; start, hit and tick are ignored there.
REQ-031 kill and bounce SHALL be 0 in every state except KILL; at most one kill bit SHALL be set per cycle.

Reset
REQ-032 reset=0 SHALL immediately force: state=IDLE, alive=all ones, kill=0, bounce=0, y_offset=0, score=0, win=0, lose=0, pend=0, cooldown counter=0.
REQ-033 Reset asserted mid-KILL or mid-COOL SHALL abort the operation with no further kill or bounce pulse after release.
REQ-034 Operation SHALL resume on the first rising clock edge after reset returns to 1.

Verification
REQ-035 Reset, start=1, then one-cycle hit=8'h24 -> one KILL cycle with kill=8'h04 and bounce=1; alive=8'hFB; score=1; HOLD COOL cycles follow, then PLAY.
REQ-036 Hit held at 8'h01 for 20 cycles -> kill[0] pulses exactly once; later cycles are ignored as a dead-block hit; score=1.
REQ-037 Hit=8'h01 and tick=1 in the same PLAY cycle -> KILL first, then COOL, PLAY, DESCEND; y_offset=16.
REQ-038 Ten ticks with no hits (defaults) -> y_offset steps 16, 32 ... 160; lose=1 after the tenth DESCEND; state=6; further ticks leave y_offset=160.
REQ-039 Kill all 8 blocks sequentially -> win=1 after the eighth KILL with score=8, no COOL entered; state=5.
REQ-040 Assert reset=0 for a partial cycle during KILL -> outputs take reset values asynchronously; no kill pulse after reset release.
